// File: rtl/pfb_sequencer.sv
// Frame pacer for the oversampled PFB PE chain: D new-sample cycles then M-D loop-buffer
// cycles per frame, with fill tracking and phase-rotation index. Optional: PFB_SEQ_STATS_EN.
module pfb_sequencer #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 32,
  parameter int DEC_FAC = 24,
  parameter int LATENCY = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       s_tvalid,
  input  logic signed [WIDTH-1:0]    s_tdata,
  output logic                       s_tready,
  input  logic                       dn_ready,
  output logic                       dp_en,
  output logic                       dp_vin,
  output logic signed [WIDTH-1:0]    dp_din,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [$clog2(FFT_LEN)-1:0] shift_idx,
  output logic                       busy
`ifdef PFB_SEQ_STATS_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                frame_cnt
`endif
);

  localparam int CW = $clog2(FFT_LEN);
  localparam int FW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW:0]   D_W   = (CW+1)'(DEC_FAC);
  localparam logic [CW:0]   M_W   = (CW+1)'(FFT_LEN);
  localparam logic [CW-1:0] LAST  = CW'(FFT_LEN - 1);
  localparam logic [FW-1:0] LAT_W = FW'(LATENCY);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cyc;
  logic [FW-1:0] fill_ctr;
  logic          stop_pend;
  logic          new_cyc, step, filled, frame_end;
  logic [CW:0]   shift_sum;

  assign busy      = (state != IDLE);
  assign new_cyc   = ({1'b0, cyc} < D_W);
  assign filled    = (fill_ctr == LAT_W);
  assign s_tready  = busy && new_cyc && dn_ready;
  // Reuse cycles advance without input; new-sample cycles wait for s_tvalid.
  assign step      = busy && dn_ready && (!new_cyc || s_tvalid);
  assign frame_end = step && (cyc == LAST);
  assign shift_sum = {1'b0, shift_idx} + D_W;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (filled) state_nxt = RUN;
      default: state_nxt = state;
    endcase
    if (busy && frame_end && stop_pend) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      fill_ctr  <= '0;
      stop_pend <= 1'b0;
      shift_idx <= '0;
      dp_en     <= 1'b0;
      dp_vin    <= 1'b0;
      dp_din    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dp_en     <= step;
      dp_vin    <= step && new_cyc;
      out_valid <= step && filled;
      out_last  <= frame_end && filled;
      if (s_tvalid && s_tready) dp_din <= s_tdata;
      if (!busy) begin
        if (start) begin
          cyc       <= '0;
          fill_ctr  <= '0;
          shift_idx <= '0;
          stop_pend <= 1'b0;
        end
      end else begin
        if (stop) stop_pend <= 1'b1;
        if (step) begin
          cyc <= (cyc == LAST) ? '0 : cyc + 1'b1;
          if (!filled) fill_ctr <= fill_ctr + 1'b1;
          // Rotation advances by D per output frame, modulo M.
          if (frame_end && filled)
            shift_idx <= (shift_sum >= M_W) ? CW'(shift_sum - M_W) : CW'(shift_sum);
        end
      end
    end
  end

`ifdef PFB_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (!busy && start)) begin
      stall_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (busy && !step) stall_cnt <= stall_cnt + 32'd1;
      if (frame_end && filled) frame_cnt <= frame_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pfb_sequencer.sv
// Scoreboarded bench for pfb_sequencer: M=32/D=24/LATENCY=256 main instance plus a D=M=32 instance.
module tb_pfb_sequencer;
  localparam int W = 16;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, s_tvalid = 1'b0, dn_ready = 1'b1;
  logic signed [W-1:0] s_tdata = 16'sd100;
  logic s_tready, dp_en, dp_vin, out_valid, out_last, busy;
  logic signed [W-1:0] dp_din;
  logic [4:0] shift_idx;

  logic start2 = 1'b0, s_tvalid2 = 1'b1, dn_ready2 = 1'b1, stop2 = 1'b0;
  logic signed [W-1:0] s_tdata2 = '0;
  logic s_tready2, dp_en2, dp_vin2, out_valid2, out_last2, busy2;
  logic signed [W-1:0] dp_din2;
  logic [4:0] shift_idx2;
`ifdef PFB_SEQ_STATS_EN
  logic [31:0] stall_cnt, frame_cnt, stall_cnt2, frame_cnt2;
`endif

  int checks = 0, errors = 0;
  int exp_q[$];
  logic adv = 1'b0;

  pfb_sequencer #(.WIDTH(W), .FFT_LEN(32), .DEC_FAC(24), .LATENCY(256)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tready(s_tready), .dn_ready(dn_ready), .dp_en(dp_en), .dp_vin(dp_vin), .dp_din(dp_din),
    .out_valid(out_valid), .out_last(out_last), .shift_idx(shift_idx), .busy(busy)
`ifdef PFB_SEQ_STATS_EN
    , .stall_cnt(stall_cnt), .frame_cnt(frame_cnt)
`endif
  );

  pfb_sequencer #(.WIDTH(W), .FFT_LEN(32), .DEC_FAC(32), .LATENCY(8)) u_dm (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .s_tvalid(s_tvalid2), .s_tdata(s_tdata2),
    .s_tready(s_tready2), .dn_ready(dn_ready2), .dp_en(dp_en2), .dp_vin(dp_vin2), .dp_din(dp_din2),
    .out_valid(out_valid2), .out_last(out_last2), .shift_idx(shift_idx2), .busy(busy2)
`ifdef PFB_SEQ_STATS_EN
    , .stall_cnt(stall_cnt2), .frame_cnt(frame_cnt2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each accepted sample must reappear exactly once on dp_din with dp_vin.
  always @(negedge clk) begin
    if (dp_vin) begin
      if (exp_q.size() == 0) chk("dp_din_unexpected", 1, 0);
      else chk("dp_din", int'(dp_din), exp_q.pop_front());
    end
    adv = s_tvalid && s_tready && !rst;
    if (adv) exp_q.push_back(int'(s_tdata));
  end

  always @(posedge clk) begin
    #1;
    if (adv) s_tdata = s_tdata + 16'sd1;
  end

  task automatic reset_outputs(input string tag);
    chk({tag, "_dp_en"}, dp_en, 0);
    chk({tag, "_dp_vin"}, dp_vin, 0);
    chk({tag, "_dp_din"}, int'(dp_din), 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_shift_idx"}, shift_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_tready"}, s_tready, 0);
  endtask

  // Counts dp_en pulses up to and including the first out_valid.
  task automatic first_valid(input string tag, input int en_start);
    int en_cnt, guard;
    en_cnt = en_start;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (dp_en) en_cnt++;
    end while (!out_valid && guard < 400);
    chk({tag, "_seen"}, out_valid, 1);
    chk({tag, "_en_count"}, en_cnt, 257);
  endtask

  initial begin
    int shexp[5] = '{0, 24, 16, 8, 0};
    int vcount, run, guard, bad_rdy, bad_sh, nlast;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_outputs("reset");

    // Frame structure: 24 accepts then 8 reuse cycles
    @(posedge clk); #1 start = 1'b1; s_tvalid = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("f1_s_tready", s_tready, int'(k < 24));
      chk("f1_dp_en", dp_en, int'(k >= 1));
      chk("f1_dp_vin", dp_vin, int'(k >= 1 && k <= 24));
    end

    // Fill latency, out_last cadence, rotation sequence
    first_valid("fill", 31);
    vcount = 1;
    chk("shift_frame0", shift_idx, shexp[0]);
    chk("out_last_v", out_last, 0);
    for (int i = 0; i < 159; i++) begin
      @(negedge clk);
      chk("valid_stream", out_valid, 1);
      vcount++;
      if (vcount % 32 == 1) chk("shift_seq", shift_idx, shexp[(vcount - 1) / 32]);
      chk("out_last_v", out_last, int'(vcount % 32 == 0));
    end

    // Input gap of 5 cycles at cyc=10
    repeat (10) @(posedge clk);
    #1 s_tvalid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("gap_dp_en", dp_en, int'(j == 0 || j == 6));
      chk("gap_s_tready", s_tready, 1);
      if (j == 4) begin @(posedge clk); #1 s_tvalid = 1'b1; end
    end
    run = 0; guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (s_tready) run++;
    end while (s_tready && guard < 100);
    chk("gap_accept_run", run, 12);

    // Downstream stall of 3 cycles at cyc=28
    repeat (4) @(posedge clk);
    #1 dn_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("dn_dp_en", dp_en, int'(j == 0 || j >= 4));
      chk("dn_s_tready", s_tready, int'(j == 7));
      chk("dn_out_last", out_last, int'(j == 7));
      if (j == 2) begin @(posedge clk); #1 dn_ready = 1'b1; end
    end

    // Stop at cyc=5 completes the frame
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    for (int i = 6; i < 34; i++) begin
      @(negedge clk);
      chk("stop_busy", busy, int'(i <= 31));
      chk("stop_dp_en", dp_en, int'(i <= 32));
      chk("stop_out_last", out_last, int'(i == 32));
    end

    // Restart refills from scratch
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("restart_shift", shift_idx, 0);
    chk("restart_valid", out_valid, 0);
    first_valid("refill", 0);
    chk("refill_shift", shift_idx, 0);

    // Reset mid-frame at cyc=17 in RUN
    repeat (48) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("prerst_shift", shift_idx, 24);
    chk("prerst_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    reset_outputs("midrst");
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // D == M: never a reuse cycle, rotation never moves
    bad_rdy = 0; bad_sh = 0; nlast = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int k = 0; k < 129; k++) begin
      @(negedge clk);
      if (!s_tready2) bad_rdy++;
      if (shift_idx2 != 0) bad_sh++;
      if (out_last2) nlast++;
    end
    chk("dm_s_tready_drops", bad_rdy, 0);
    chk("dm_shift_nonzero", bad_sh, 0);
    chk("dm_out_last_count", nlast, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
